// File: rtl/sockit_spi_arb.sv
// sockit_spi_arb: round-robin arbiter sharing one sockit_spi command stream
// between N requesters. Grant is held for a burst, optionally capped at BURST
// transfers. The data path is a combinational pass-through from the granted
// requester; grant, pointer and counter are registered.
module sockit_spi_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned BURST = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N*DW-1:0] req_dat,
  output logic [N-1:0]    req_rdy,
  output logic            out_vld,
  output logic [DW-1:0]   out_dat,
  input  logic            out_rdy,
  output logic [N-1:0]    gnt,
  output logic            busy
);

  localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW       = (BURST > 0) ? $clog2(BURST + 1) : 1;
  localparam bit          LIMITED  = (BURST != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((BURST > 0) ? BURST - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic          sel_vld;
  logic [DW-1:0] sel_dat;
  logic          hi_found;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] pick;
  logic          xfer;

  // Mux out the valid/data of the currently granted requester.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (g_q == IW'(i)) begin
        sel_vld = req_vld[i];
        sel_dat = req_dat[i*DW +: DW];
      end
    end
  end

  // Round-robin pick: lowest valid index above p wins, else lowest at or below p.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        if (IW'(i) > p_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end else begin
          lo_idx   = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_idx : lo_idx;
  end

  // Next-state, counter, pointer and pass-through stream outputs.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    out_vld = 1'b0;
    out_dat = '0;
    req_rdy = '0;
    xfer    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_vld) begin
          state_d = GRANT;
          g_d     = pick;
          cnt_d   = '0;
          for (int i = 0; i < int'(N); i++) begin
            gnt_d[i] = (pick == IW'(i));
          end
        end
      end

      GRANT: begin
        out_vld = sel_vld;
        out_dat = sel_dat;
        for (int i = 0; i < int'(N); i++) begin
          req_rdy[i] = (g_q == IW'(i)) && out_rdy;
        end
        xfer = sel_vld && out_rdy;
        if (xfer && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Release on vld drop or on the last transfer of a capped burst.
        if (!sel_vld || (LIMITED && xfer && (cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          p_d     = g_q;
          cnt_d   = '0;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; pointer resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= IW'(N - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scoreboard bench for sockit_spi_arb: instance 0 uses BURST=4, instance 1
// uses BURST=0 (unlimited). Requester models feed per-source word queues;
// expected transfers are queued in hand-computed order and checked by a monitor.
module tb_sockit_spi_arb;

  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] d;
  } xfer_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_vld [2];
  logic [63:0] req_dat [2];
  logic [1:0]  req_rdy [2];
  logic        out_vld [2];
  logic [31:0] out_dat [2];
  logic        out_rdy [2];
  logic [1:0]  gnt     [2];
  logic        busy    [2];

  logic        rdy_en  [2];
  logic [1:0]  fire    [2];
  logic [31:0] sq      [4][$];
  xfer_t       exp_q   [2][$];
  xfer_t       mon_e;

  int n_cmp = 0;
  int n_err = 0;

  sockit_spi_arb #(.N(2), .DW(32), .BURST(4)) u_dut_b4 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld[0]), .req_dat(req_dat[0]), .req_rdy(req_rdy[0]),
    .out_vld(out_vld[0]), .out_dat(out_dat[0]), .out_rdy(out_rdy[0]),
    .gnt(gnt[0]), .busy(busy[0])
  );

  sockit_spi_arb #(.N(2), .DW(32), .BURST(0)) u_dut_b0 (
    .clk(clk), .rst(rst),
    .req_vld(req_vld[1]), .req_dat(req_dat[1]), .req_rdy(req_rdy[1]),
    .out_vld(out_vld[1]), .out_dat(out_dat[1]), .out_rdy(out_rdy[1]),
    .gnt(gnt[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endfunction

  task automatic chk_st(input int k, input string nm, input logic [1:0] g, input logic b, input logic v);
    chk($sformatf("%s[u%0d] {gnt,busy,out_vld}", nm, k),
        64'({gnt[k], busy[k], out_vld[k]}), 64'({g, b, v}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int k, input int r, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sq[k*2+r].push_back(base + 32'(i));
  endtask

  task automatic push_exp(input int k, input logic [1:0] g, input logic [31:0] base, input int n);
    xfer_t e;
    for (int i = 0; i < n; i++) begin
      e.g = g;
      e.d = base + 32'(i);
      exp_q[k].push_back(e);
    end
  endtask

  // Requester sources: pop on handshake, present next word after each edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      req_vld[k] = '0;
      req_dat[k] = '0;
      out_rdy[k] = 1'b1;
      fire[k]    = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) fire[k] = req_vld[k] & req_rdy[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 2; r++) begin
          if (fire[k][r] && sq[k*2+r].size() != 0) void'(sq[k*2+r].pop_front());
          req_vld[k][r]          = (sq[k*2+r].size() != 0);
          req_dat[k][r*32 +: 32] = (sq[k*2+r].size() != 0) ? sq[k*2+r][0] : 32'h0;
        end
        out_rdy[k] = rdy_en[k];
      end
    end
  end

  // Monitor: every output transfer is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (out_vld[k] && out_rdy[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL xfer[u%0d]: unexpected transfer gnt=%b dat=%h, expected none",
                     k, gnt[k], out_dat[k]);
          end else begin
            mon_e = exp_q[k].pop_front();
            chk($sformatf("xfer[u%0d] {gnt,dat}", k),
                64'({gnt[k], out_dat[k]}), 64'({mon_e.g, mon_e.d}));
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    rdy_en[0] = 1'b1;
    rdy_en[1] = 1'b1;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      chk_st(k, "reset", 2'b00, 1'b0, 1'b0);
      chk($sformatf("reset[u%0d] req_rdy", k), 64'(req_rdy[k]), 64'd0);
      chk($sformatf("reset[u%0d] out_dat", k), 64'(out_dat[k]), 64'd0);
    end
    rst = 1'b0;
    tick(1);

    // Single requester, unlimited burst: 5 words then vld drop.
    load(1, 0, 32'h10, 5);
    push_exp(1, 2'b01, 32'h10, 5);
    tick(1); chk_st(1, "t1_idle", 2'b00, 1'b0, 1'b0);
    tick(1); chk_st(1, "t1_grant", 2'b01, 1'b1, 1'b1);
    tick(5); chk_st(1, "t1_drop", 2'b01, 1'b1, 1'b0);
    tick(1); chk_st(1, "t1_release", 2'b00, 1'b0, 1'b0);
    tick(2);

    // Round robin, BURST=4, both continuously valid.
    load(0, 0, 32'hA0, 8);
    load(0, 1, 32'hB0, 8);
    push_exp(0, 2'b01, 32'hA0, 4);
    push_exp(0, 2'b10, 32'hB0, 4);
    push_exp(0, 2'b01, 32'hA4, 4);
    push_exp(0, 2'b10, 32'hB4, 4);
    tick(2); chk_st(0, "t2_g0", 2'b01, 1'b1, 1'b1);
    tick(3); chk_st(0, "t2_g0_last", 2'b01, 1'b1, 1'b1);
    tick(1); chk_st(0, "t2_bubble1", 2'b00, 1'b0, 1'b0);
    tick(1); chk_st(0, "t2_g1", 2'b10, 1'b1, 1'b1);
    tick(4); chk_st(0, "t2_bubble2", 2'b00, 1'b0, 1'b0);
    tick(1); chk_st(0, "t2_g0b", 2'b01, 1'b1, 1'b1);
    tick(5); chk_st(0, "t2_g1b", 2'b10, 1'b1, 1'b1);
    tick(4); chk_st(0, "t2_end", 2'b00, 1'b0, 1'b0);
    tick(2);

    // Backpressure: 3-cycle stall mid-burst on requester 1.
    load(0, 1, 32'hC0, 4);
    push_exp(0, 2'b10, 32'hC0, 4);
    tick(2); chk_st(0, "t3_grant", 2'b10, 1'b1, 1'b1);
    tick(1); rdy_en[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick(1);
      chk_st(0, "t3_stall", 2'b10, 1'b1, 1'b1);
      chk("t3_stall req_rdy", 64'(req_rdy[0]), 64'd0);
      chk("t3_stall out_dat", 64'(out_dat[0]), 64'h0000_00C2);
    end
    rdy_en[0] = 1'b1;
    tick(1); chk_st(0, "t3_resume", 2'b10, 1'b1, 1'b1);
    tick(1); chk_st(0, "t3_last", 2'b10, 1'b1, 1'b1);
    tick(1); chk_st(0, "t3_release", 2'b00, 1'b0, 1'b0);
    tick(2);

    // Unlimited burst: 40 words from requester 0 while requester 1 waits.
    load(1, 0, 32'h100, 40);
    push_exp(1, 2'b01, 32'h100, 40);
    push_exp(1, 2'b10, 32'h200, 2);
    tick(2); chk_st(1, "t4_grant0", 2'b01, 1'b1, 1'b1);
    load(1, 1, 32'h200, 2);
    tick(40); chk_st(1, "t4_drop", 2'b01, 1'b1, 1'b0);
    tick(1); chk_st(1, "t4_bubble", 2'b00, 1'b0, 1'b0);
    tick(1); chk_st(1, "t4_grant1", 2'b10, 1'b1, 1'b1);
    tick(4);

    // Vld drop while cnt==BURST-1 without a transfer: single release, p=0.
    load(0, 0, 32'hD0, 3);
    push_exp(0, 2'b01, 32'hD0, 3);
    push_exp(0, 2'b10, 32'hF0, 1);
    push_exp(0, 2'b01, 32'hE0, 1);
    tick(2); chk_st(0, "t5_grant", 2'b01, 1'b1, 1'b1);
    tick(3); chk_st(0, "t5_drop", 2'b01, 1'b1, 1'b0);
    load(0, 0, 32'hE0, 1);
    load(0, 1, 32'hF0, 1);
    tick(1); chk_st(0, "t5_release", 2'b00, 1'b0, 1'b0);
    tick(1); chk_st(0, "t5_next_is_1", 2'b10, 1'b1, 1'b1);
    tick(3); chk_st(0, "t5_then_0", 2'b01, 1'b1, 1'b1);
    tick(3);

    // Async reset mid-burst: requester 1 granted, reset between edges.
    load(0, 1, 32'h60, 4);
    load(0, 0, 32'h70, 4);
    push_exp(0, 2'b10, 32'h60, 2);
    push_exp(0, 2'b01, 32'h70, 4);
    push_exp(0, 2'b10, 32'h62, 2);
    tick(2); chk_st(0, "t6_grant1", 2'b10, 1'b1, 1'b1);
    tick(1); chk_st(0, "t6_mid", 2'b10, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_st(0, "t6_rst", 2'b00, 1'b0, 1'b0);
    chk("t6_rst req_rdy", 64'(req_rdy[0]), 64'd0);
    chk("t6_rst out_dat", 64'(out_dat[0]), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1); chk_st(0, "t6_post_g0", 2'b01, 1'b1, 1'b1);
    tick(5); chk_st(0, "t6_post_g1", 2'b10, 1'b1, 1'b1);
    tick(4);

    chk("drain u0", 64'(exp_q[0].size()), 64'd0);
    chk("drain u1", 64'(exp_q[1].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
